// File: rtl/mixer_ctrl_pkg.sv
// Shared definitions for the mixer retune controller.
// Contents: controller state encoding, default widths for the phase increment,
// settle counter and retune counter.
package mixer_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StFlush = 2'd2,
    StRun   = 2'd3
  } state_t;

  localparam int unsigned DefPhaseW  = 32;
  localparam int unsigned DefSettleW = 16;
  localparam int unsigned DefCntW    = 8;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times the CIC flush window.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        load cnt with load_val (wins over en)
//   en          decrement by one; holds at zero, never wraps
//   load_val    value to load (SETTLE_W bits)
//   zero        count is zero
module settle_timer
  import mixer_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_W = DefSettleW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [SETTLE_W-1:0] load_val,
  output logic                zero
);

  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mixer_tune_ctrl.sv
// Retune sequencer for the NCO -> sin/cos mixer -> CIC decimator path.
// A tuning request (valid/ready) loads the phase increment, pulses the NCO
// phase clear, holds the CIC in flush with the mixer gated off for
// max(settle_cycles,1) cycles, then declares lock.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   tune_valid/ready request handshake; ready is high in IDLE and RUN
//   tune_word       requested phase increment, sampled on transfer
//   settle_cycles   flush length for this request, sampled on transfer
//   phase_inc       registered phase increment to the NCO
//   phase_clr       one-cycle NCO accumulator clear (the LOAD cycle)
//   mix_gate        1 = mixer outputs passed downstream
//   cic_flush       hold CIC integrators/combs cleared
//   locked          path settled at phase_inc
//   retune_cnt      saturating count of completed retunes
// Build option: define MIXER_TUNE_CNT_EN to add CNT_W and the retune_cnt port.
module mixer_tune_ctrl
  import mixer_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_W  = DefPhaseW,
  parameter int unsigned SETTLE_W = DefSettleW
`ifdef MIXER_TUNE_CNT_EN
  ,
  parameter int unsigned CNT_W    = DefCntW
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tune_valid,
  output logic                tune_ready,
  input  logic [PHASE_W-1:0]  tune_word,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [PHASE_W-1:0]  phase_inc,
  output logic                phase_clr,
  output logic                mix_gate,
  output logic                cic_flush,
  output logic                locked
`ifdef MIXER_TUNE_CNT_EN
  ,
  output logic [CNT_W-1:0]    retune_cnt
`endif
);

  state_t              state_q;
  logic [PHASE_W-1:0]  word_q;
  logic [SETTLE_W-1:0] settle_m1;
  logic                xfer;
  logic                timer_zero;
  logic                flush_done;

  assign tune_ready = (state_q == StIdle) || (state_q == StRun);
  assign xfer       = tune_valid && tune_ready;
  assign flush_done = (state_q == StFlush) && timer_zero;

  // settle_cycles == 0 behaves as 1: the flush always lasts at least one cycle.
  assign settle_m1 = (settle_cycles == '0) ? '0 : settle_cycles - SETTLE_W'(1);

  // Loaded on the accepting edge; it idles through LOAD, so FLUSH sees the
  // full max(S,1) cycles.
  settle_timer #(
    .SETTLE_W (SETTLE_W)
  ) u_settle_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (xfer),
    .en       (state_q == StFlush),
    .load_val (settle_m1),
    .zero     (timer_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      word_q    <= '0;
      phase_inc <= '0;
      phase_clr <= 1'b0;
      mix_gate  <= 1'b0;
      cic_flush <= 1'b1;
      locked    <= 1'b0;
    end else begin
      phase_clr <= 1'b0;
      case (state_q)
        StIdle, StRun: begin
          if (xfer) begin
            state_q   <= StLoad;
            word_q    <= tune_word;
            phase_clr <= 1'b1;
            mix_gate  <= 1'b0;
            cic_flush <= 1'b1;
            locked    <= 1'b0;
          end
        end
        StLoad: begin
          // Old increment stays on the NCO until here so the switch is atomic.
          phase_inc <= word_q;
          state_q   <= StFlush;
        end
        StFlush: begin
          if (timer_zero) begin
            state_q   <= StRun;
            mix_gate  <= 1'b1;
            cic_flush <= 1'b0;
            locked    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MIXER_TUNE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retune_cnt <= '0;
    end else if (flush_done && (retune_cnt != '1)) begin
      retune_cnt <= retune_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_flush_done;
  assign unused_flush_done = flush_done;
`endif

endmodule

// File: tb/tb_mixer_tune_ctrl.sv
// Self-checking bench for mixer_tune_ctrl. Accepted requests are pushed to a
// scoreboard queue; a negedge monitor pops them when lock rises and checks
// timing, phase increment and (with MIXER_TUNE_CNT_EN) the retune count.
module tb_mixer_tune_ctrl;

`ifdef MIXER_TUNE_CNT_EN
  localparam int unsigned CntW = 2;
`endif

  logic        clk;
  logic        rst_n;
  logic        tune_valid;
  logic        tune_ready;
  logic [31:0] tune_word;
  logic [15:0] settle_cycles;
  logic [31:0] phase_inc;
  logic        phase_clr;
  logic        mix_gate;
  logic        cic_flush;
  logic        locked;
`ifdef MIXER_TUNE_CNT_EN
  logic [CntW-1:0] retune_cnt;
`endif

  mixer_tune_ctrl #(
    .PHASE_W  (32),
    .SETTLE_W (16)
`ifdef MIXER_TUNE_CNT_EN
    ,
    .CNT_W    (CntW)
`endif
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tune_valid    (tune_valid),
    .tune_ready    (tune_ready),
    .tune_word     (tune_word),
    .settle_cycles (settle_cycles),
    .phase_inc     (phase_inc),
    .phase_clr     (phase_clr),
    .mix_gate      (mix_gate),
    .cic_flush     (cic_flush),
    .locked        (locked)
`ifdef MIXER_TUNE_CNT_EN
    ,
    .retune_cnt    (retune_cnt)
`endif
  );

  typedef struct {
    logic [31:0] word;
    int          settle;
    int          acc;    // cyc value in the cycle before the accepting edge
  } req_t;

  req_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic locked_prev = 1'b0;
  int   exp_cnt  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: output coherence every cycle, scoreboard pops on lock rise.
  always @(negedge clk) begin
    check_eq("gate_eq_lock", {31'd0, mix_gate}, {31'd0, locked});
    check_eq("flush_eq_nlock", {31'd0, cic_flush}, {31'd0, ~locked});
    if (rst_n) begin
      if (phase_clr) begin
        if (exp_q.size() == 0) check_eq("spurious_clr", 32'd1, 32'd0);
        else check_eq("clr_cycle", cyc, exp_q[0].acc + 1);
      end
      if (locked && !locked_prev) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_lock", 32'd1, 32'd0);
        end else begin
          req_t r;
          r = exp_q.pop_front();
          check_eq("lock_cycle", cyc, r.acc + 2 + ((r.settle == 0) ? 1 : r.settle));
          check_eq("lock_word", phase_inc, r.word);
`ifdef MIXER_TUNE_CNT_EN
          if (exp_cnt < (1 << CntW) - 1) exp_cnt++;
          check_eq("retune_cnt", {30'd0, retune_cnt}, exp_cnt);
`endif
        end
      end
    end
    locked_prev = locked;
  end

  // Drive a request from a negedge, hold valid until accepted; returns the
  // acceptance cycle and how many cycles ready was low while waiting.
  task automatic send(input logic [31:0] w, input int s, output int acc, output int waited);
    waited        = 0;
    tune_valid    = 1'b1;
    tune_word     = w;
    settle_cycles = 16'(s);
    while (!tune_ready && waited < 5000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 5000) check_eq("send_timeout", 32'd0, 32'd1);
    acc = cyc;
    exp_q.push_back('{w, s, cyc});
    @(negedge clk);
    tune_valid = 1'b0;
  endtask

  task automatic wait_lock(input int limit);
    int n = 0;
    while (!locked && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!locked) check_eq("lock_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int acc1, acc2, w1, w2;
    rst_n         = 1'b0;
    tune_valid    = 1'b0;
    tune_word     = '0;
    settle_cycles = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_eq("idle_phase_inc", phase_inc, 32'd0);
      check_eq("idle_ready", {31'd0, tune_ready}, 32'd1);
      check_eq("idle_locked", {31'd0, locked}, 32'd0);
      check_eq("idle_flush", {31'd0, cic_flush}, 32'd1);
      check_eq("idle_clr", {31'd0, phase_clr}, 32'd0);
    end

    // Basic retune, settle 10.
    send(32'h0147_AE14, 10, acc1, w1);
    check_eq("load_clr", {31'd0, phase_clr}, 32'd1);
    check_eq("load_old_inc", phase_inc, 32'd0);
    check_eq("load_ready", {31'd0, tune_ready}, 32'd0);
    @(negedge clk);
    check_eq("flush_clr_low", {31'd0, phase_clr}, 32'd0);
    check_eq("flush_new_inc", phase_inc, 32'h0147_AE14);
    wait_lock(50);

    // settle_cycles = 0 acts as 1.
    send(32'h0000_1234, 0, acc1, w1);
    wait_lock(50);

    // Second request held during FLUSH, taken at the first RUN cycle.
    send(32'h0200_0000, 4, acc1, w1);
    send(32'h0300_0000, 3, acc2, w2);
    check_eq("held_wait", w2, 32'd5);
    check_eq("held_accept", acc2, acc1 + 6);
    wait_lock(50);
    check_eq("final_inc", phase_inc, 32'h0300_0000);

    // Reset mid-FLUSH.
    send(32'h0ABC_DEF0, 1000, acc1, w1);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    #1;
    check_eq("rst_phase_inc", phase_inc, 32'd0);
    check_eq("rst_locked", {31'd0, locked}, 32'd0);
    check_eq("rst_flush", {31'd0, cic_flush}, 32'd1);
    check_eq("rst_gate", {31'd0, mix_gate}, 32'd0);
    check_eq("rst_ready", {31'd0, tune_ready}, 32'd1);
`ifdef MIXER_TUNE_CNT_EN
    check_eq("rst_cnt", {30'd0, retune_cnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (i % 100 == 0) begin
        check_eq("post_rst_locked", {31'd0, locked}, 32'd0);
        check_eq("post_rst_inc", phase_inc, 32'd0);
      end
    end

    // Back-to-back same-word retunes (retune_cnt 1,2,3,3,3 when CNT_W=2).
    for (int i = 0; i < 5; i++) begin
      send(32'h0055_AA00, 2, acc1, w1);
    end
    wait_lock(50);
    repeat (2) @(negedge clk);
    check_eq("sb_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
